// File: rtl/wb_spi_bridge.sv
// Wishbone slave that decodes per-channel DATA/CMD/STATUS registers and turns
// bus accesses into single-cycle internal requests with timeout supervision.
module wb_spi_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DATA_W    = 9,
  parameter int          CMD_W     = 11,
  parameter int          CH        = 4,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wb_addr,
  input  logic              wb_we,
  input  logic              wb_stb,
  input  logic              wb_cyc,
  input  logic [31:0]       wb_dout,
  output logic [31:0]       wb_din,
  output logic              wb_ack,
  output logic              wb_err,
  output logic [CMD_W-1:0]  dout,
  output logic              cmd,
  output logic              wr,
  output logic              rd,
  output logic [CH-1:0]     ch_sel,
  input  logic [DATA_W-1:0] din,
  input  logic              ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [7:0] OFF_DATA = 8'h10;
  localparam logic [7:0] OFF_CMD  = 8'h20;
  localparam logic [7:0] OFF_STAT = 8'h30;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [15:0]       r_wait_cnt;
  logic [7:0]        r_tmo_cnt;
  logic              r_sticky_err;
  logic              r_is_read;
  logic [31:0]       r_wb_din;
  logic              r_wb_ack;
  logic              r_wb_err;
  logic [CMD_W-1:0]  r_dout;
  logic              r_cmd;
  logic              r_wr;
  logic              r_rd;
  logic [CH-1:0]     r_ch_sel;

  logic              w_hit;
  logic [3:0]        w_chan;
  logic [7:0]        w_off;
  logic              w_chan_ok;
  logic              w_is_data;
  logic              w_is_cmd;
  logic              w_is_stat;
  logic              w_bad;
  logic              w_start;
  logic [CH-1:0]     w_onehot;
  logic              w_unused;

  assign w_hit     = (wb_addr[31:16] == BASE_ADDR[31:16]);
  assign w_chan    = wb_addr[15:12];
  assign w_off     = wb_addr[7:0];
  assign w_chan_ok = ({1'b0, w_chan} < 5'(CH));
  assign w_is_data = (w_off == OFF_DATA);
  assign w_is_cmd  = (w_off == OFF_CMD);
  assign w_is_stat = (w_off == OFF_STAT);
  // The command register is write-only, so a read of it is an error.
  assign w_bad     = !w_chan_ok || !(w_is_data || w_is_cmd || w_is_stat) ||
                     (w_is_cmd && !wb_we);
  assign w_start   = wb_cyc && wb_stb && w_hit;
  assign w_unused  = ^{wb_addr[11:8], wb_dout};

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < CH; i++) begin
      w_onehot[i] = (w_chan == 4'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_sticky_err <= 1'b0;
      r_is_read    <= 1'b0;
      r_wb_din     <= '0;
      r_wb_ack     <= 1'b0;
      r_wb_err     <= 1'b0;
      r_dout       <= '0;
      r_cmd        <= 1'b0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_ch_sel     <= '0;
    end else begin
      r_cmd    <= 1'b0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_wb_ack <= 1'b0;
      r_wb_err <= 1'b0;
      r_wb_din <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_bad) begin
              r_wb_err <= 1'b1;
              r_state  <= S_RESP;
            end else if (w_is_stat) begin
              r_wb_ack <= 1'b1;
              r_state  <= S_RESP;
              if (!wb_we) begin
                r_wb_din <= {23'b0, r_sticky_err, r_tmo_cnt};
              end else if (wb_dout[8]) begin
                r_sticky_err <= 1'b0;
                r_tmo_cnt    <= '0;
              end
            end else begin
              r_state    <= S_REQ;
              r_wait_cnt <= '0;
              r_is_read  <= !wb_we;
              r_dout     <= wb_dout[CMD_W-1:0];
              r_ch_sel   <= w_onehot;
              r_wr       <= w_is_data && wb_we;
              r_rd       <= w_is_data && !wb_we;
              r_cmd      <= w_is_cmd;
            end
          end
        end
        S_REQ, S_WAIT: begin
          // Abort has priority: once the master leaves, nothing is reported.
          if (!wb_cyc) begin
            r_state <= S_IDLE;
          end else if (ack) begin
            r_wb_ack <= 1'b1;
            r_state  <= S_RESP;
            if (r_is_read) begin
              r_wb_din <= 32'(din);
            end
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_wb_err     <= 1'b1;
            r_sticky_err <= 1'b1;
            r_state      <= S_RESP;
            if (r_tmo_cnt != 8'hFF) begin
              r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
            r_state    <= S_WAIT;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb_din = r_wb_din;
  assign wb_ack = r_wb_ack;
  assign wb_err = r_wb_err;
  assign dout   = r_dout;
  assign cmd    = r_cmd;
  assign wr     = r_wr;
  assign rd     = r_rd;
  assign ch_sel = r_ch_sel;

endmodule

// File: tb/tb_wb_spi_bridge.sv
// Self-checking bench for wb_spi_bridge: directed cases plus randomized
// transactions compared cycle by cycle against a transaction-level model.
module tb_wb_spi_bridge;

  localparam logic [31:0] BASE = 32'h3C00_0000;
  localparam int DW  = 9;
  localparam int CW  = 11;
  localparam int NCH = 4;
  localparam int TMO = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    wb_addr;
  logic           wb_we;
  logic           wb_stb;
  logic           wb_cyc;
  logic [31:0]    wb_dout;
  logic [31:0]    wb_din;
  logic           wb_ack;
  logic           wb_err;
  logic [CW-1:0]  dout;
  logic           cmd;
  logic           wr;
  logic           rd;
  logic [NCH-1:0] ch_sel;
  logic [DW-1:0]  din;
  logic           ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: status fields and the last latched request.
  logic           m_sticky;
  logic [7:0]     m_tmo;
  logic [CW-1:0]  m_dout;
  logic [NCH-1:0] m_ch_sel;
  bit             m_in_resp;

  wb_spi_bridge #(
    .BASE_ADDR (BASE),
    .DATA_W    (DW),
    .CMD_W     (CW),
    .CH        (NCH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wb_addr (wb_addr),
    .wb_we   (wb_we),
    .wb_stb  (wb_stb),
    .wb_cyc  (wb_cyc),
    .wb_dout (wb_dout),
    .wb_din  (wb_din),
    .wb_ack  (wb_ack),
    .wb_err  (wb_err),
    .dout    (dout),
    .cmd     (cmd),
    .wr      (wr),
    .rd      (rd),
    .ch_sel  (ch_sel),
    .din     (din),
    .ack     (ack)
  );

  always #5 clk = ~clk;

  // Layout: {pad, ack, err, cmd, wr, rd, ch_sel, dout, wb_din}
  function automatic logic [63:0] pack(input logic a, input logic e, input logic c,
                                       input logic w, input logic r,
                                       input logic [NCH-1:0] cs, input logic [CW-1:0] d,
                                       input logic [31:0] dn);
    return {12'b0, a, e, c, w, r, cs, d, dn};
  endfunction

  function automatic logic [63:0] observed();
    return pack(wb_ack, wb_err, cmd, wr, rd, ch_sel, dout, wb_din);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] idle_exp();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_ch_sel, m_dout, 32'h0);
  endfunction

  function automatic logic [31:0] status_word();
    return {23'b0, m_sticky, m_tmo};
  endfunction

  // One bus transaction. Called just after a rising edge. ack_at is the index
  // of the REQ/WAIT cycle carrying the internal ack (0 = REQ cycle), -1 = none.
  // keep leaves the strobe high after the response for a back-to-back access.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic we,
                      input logic [31:0] wdata, input int ack_at,
                      input logic [DW-1:0] dval, input bit keep);
    logic        hit;
    int          chan;
    logic [7:0]  off;
    bit          is_stat, is_err, req_ok, timed_out;
    logic        p_cmd, p_wr, p_rd;
    int          resp_cyc, last;
    bit          resp_err;
    logic [31:0] resp_din;

    wb_addr = addr;
    wb_we   = we;
    wb_dout = wdata;
    din     = dval;
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    if (m_in_resp) begin
      @(posedge clk); #1;
      check({tag, " b2b gap"}, observed(), idle_exp());
      m_in_resp = 1'b0;
    end

    hit       = (addr[31:16] == BASE[31:16]);
    chan      = int'(addr[15:12]);
    off       = addr[7:0];
    is_stat   = (off == 8'h30);
    is_err    = (chan >= NCH) || !(is_stat || off == 8'h10 || (off == 8'h20 && we));
    req_ok    = hit && !is_err && !is_stat;
    p_wr      = req_ok && off == 8'h10 && we;
    p_rd      = req_ok && off == 8'h10 && !we;
    p_cmd     = req_ok && off == 8'h20;
    timed_out = req_ok && ack_at < 0;
    resp_err  = 1'b0;
    resp_din  = 32'h0;
    resp_cyc  = 0;
    if (hit && is_err) begin
      resp_cyc = 1;
      resp_err = 1'b1;
    end else if (hit && is_stat) begin
      resp_cyc = 1;
      if (!we) resp_din = status_word();
    end else if (req_ok) begin
      m_dout           = wdata[CW-1:0];
      m_ch_sel         = '0;
      m_ch_sel[chan]   = 1'b1;
      if (ack_at >= 0) begin
        resp_cyc = 2 + ack_at;
        if (!we) resp_din = 32'(dval);
      end else begin
        resp_cyc = TMO + 1;
        resp_err = 1'b1;
      end
    end
    last = hit ? (resp_cyc + (keep ? 0 : 1)) : 3;

    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s c%0d", tag, k), observed(),
            pack(k == resp_cyc && !resp_err, k == resp_cyc && resp_err,
                 p_cmd && k == 1, p_wr && k == 1, p_rd && k == 1,
                 m_ch_sel, m_dout, (k == resp_cyc) ? resp_din : 32'h0));
      ack = req_ok && ack_at >= 0 && (k == 1 + ack_at);
      if (hit ? (k == resp_cyc) : (k == last)) begin
        if (keep && hit) begin
          m_in_resp = 1'b1;
        end else begin
          wb_cyc = 1'b0;
          wb_stb = 1'b0;
        end
      end
    end
    ack = 1'b0;

    if (hit && is_stat && we && wdata[8]) begin
      m_sticky = 1'b0;
      m_tmo    = 8'h00;
    end
    if (timed_out) begin
      m_sticky = 1'b1;
      if (m_tmo != 8'hFF) m_tmo = m_tmo + 8'd1;
    end
  endtask

  initial begin
    logic [15:0] hi;
    logic [3:0]  r_chan, r_mid;
    logic [7:0]  r_off;
    int          sel;

    rst      = 1'b0;
    wb_addr  = '0;
    wb_we    = 1'b0;
    wb_stb   = 1'b0;
    wb_cyc   = 1'b0;
    wb_dout  = '0;
    din      = '0;
    ack      = 1'b0;
    m_sticky = 1'b0;
    m_tmo    = 8'h00;
    m_dout   = '0;
    m_ch_sel = '0;
    m_in_resp = 1'b0;

    #12;
    check("reset state", observed(), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", observed(), 64'h0);

    // Data write to channel 1, ack on the third REQ/WAIT cycle
    xfer("data wr ch1", BASE | 32'h1010, 1'b1, 32'h0000_0155, 2, 9'h000, 1'b0);
    // Data read on channel 0 with immediate ack
    xfer("data rd ch0", BASE | 32'h0010, 1'b0, 32'h0, 0, 9'h1A5, 1'b0);
    // Read that never completes times out, then status shows one timeout
    xfer("rd timeout", BASE | 32'h0010, 1'b0, 32'h0, -1, 9'h0FF, 1'b0);
    xfer("status rd 0x101", BASE | 32'h0030, 1'b0, 32'h0, -1, 9'h0, 1'b0);
    // Error terminations: channel out of range, unmapped offset, command read
    xfer("bad channel", BASE | 32'h5010, 1'b1, 32'h0000_0033, 0, 9'h0, 1'b0);
    xfer("bad offset", BASE | 32'h0040, 1'b0, 32'h0, 0, 9'h0, 1'b0);
    xfer("cmd read", BASE | 32'h2020, 1'b0, 32'h0, 0, 9'h0, 1'b0);
    // Status clear, then status reads zero
    xfer("status clear", BASE | 32'h0030, 1'b1, 32'h0000_0100, -1, 9'h0, 1'b0);
    xfer("status rd 0", BASE | 32'h0030, 1'b0, 32'h0, -1, 9'h0, 1'b0);
    // Address outside the slave window gets no response at all
    xfer("no hit", 32'h1234_1010, 1'b1, 32'h0000_0077, 0, 9'h0, 1'b0);
    // Ack arriving on the last allowed cycle beats the timeout
    xfer("ack at limit", BASE | 32'h3010, 1'b0, 32'h0000_0400, TMO - 1, 9'h0C3, 1'b0);
    xfer("status after limit", BASE | 32'h0030, 1'b0, 32'h0, -1, 9'h0, 1'b0);
    // Command write and back-to-back accesses with strobe held high
    xfer("cmd wr ch3", BASE | 32'h3020, 1'b1, 32'hFFFF_F7E5, 1, 9'h0, 1'b1);
    xfer("b2b data rd", BASE | 32'h2010, 1'b0, 32'h0000_0123, 0, 9'h15A, 1'b1);
    xfer("b2b status rd", BASE | 32'h1030, 1'b0, 32'h0, -1, 9'h0, 1'b0);

    // Master abandons the cycle in WAIT; a later ack must not complete it
    wb_addr = BASE | 32'h1010;
    wb_we   = 1'b0;
    wb_dout = 32'h0000_00AB;
    din     = 9'h0EE;
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    @(posedge clk); #1;
    m_dout   = 11'h0AB;
    m_ch_sel = 4'b0010;
    check("abort c1", observed(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_ch_sel, m_dout, 32'h0));
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort c%0d", k), observed(), idle_exp());
      if (k == 2) begin
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
      end
      ack = (k == 3);
    end
    ack = 1'b0;
    xfer("status after abort", BASE | 32'h0030, 1'b0, 32'h0, -1, 9'h0, 1'b0);

    // Randomized transactions against the model
    for (int n = 0; n < 40; n++) begin
      hi     = ($urandom_range(0, 9) == 0) ? 16'h1234 : BASE[31:16];
      r_chan = 4'($urandom_range(0, 5));
      r_mid  = 4'($urandom_range(0, 15));
      sel    = int'($urandom_range(0, 4));
      case (sel)
        0:       r_off = 8'h10;
        1:       r_off = 8'h20;
        2:       r_off = 8'h30;
        3:       r_off = 8'h40;
        default: r_off = 8'h11;
      endcase
      xfer($sformatf("rand%0d", n), {hi, r_chan, r_mid, r_off}, 1'($urandom_range(0, 1)),
           $urandom, int'($urandom_range(0, TMO)) - 1, DW'($urandom),
           (n != 39) && ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a WAIT
    wb_addr = BASE | 32'h2010;
    wb_we   = 1'b0;
    wb_dout = 32'h0000_05AA;
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    @(posedge clk); #1;
    m_dout   = 11'h5AA;
    m_ch_sel = 4'b0100;
    check("pre-reset rd", observed(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_ch_sel, m_dout, 32'h0));
    @(posedge clk); #1;
    check("pre-reset wait", observed(), idle_exp());
    #2 rst = 1'b0;
    #1;
    check("async reset", observed(), 64'h0);
    m_sticky = 1'b0;
    m_tmo    = 8'h00;
    m_dout   = '0;
    m_ch_sel = '0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post-reset c%0d", k), observed(), 64'h0);
    end
    xfer("status after reset", BASE | 32'h0030, 1'b0, 32'h0, -1, 9'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
